instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_fifo.sv | 59 +++++
 rtl/instr_fetch.sv | 99 +++++++++
 tb/tb_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_WIDTH_INSTR = 16;
  localparam int DEF_WIDTH_JDATA = 24;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int FETCH_CNT_W     = 32;

  typedef logic [DEF_WIDTH_JDATA-1:0] pc_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small register-based prefetch FIFO; head is read straight from storage so
// the consumer sees it with no extra latency. Entries reset to zero.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH_INSTR,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push && !clear && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  // Clear wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, read credit and jump flush around a prefetch FIFO.
// Optional FETCH_PERF_EN adds saturating fetch_cnt / bubble_cnt outputs.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int WIDTH_INSTR = DEF_WIDTH_INSTR,
  parameter int WIDTH_JDATA = DEF_WIDTH_JDATA,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   next_instr,
  input  logic                   jump,
  input  logic [WIDTH_JDATA-1:0] jdata,
  output logic                   imem_rd,
  output logic [WIDTH_JDATA-1:0] imem_addr,
  input  logic [WIDTH_INSTR-1:0] imem_rdata,
  output logic [WIDTH_INSTR-1:0] instr,
  output logic                   valid
`ifdef FETCH_PERF_EN
  ,
  output logic [FETCH_CNT_W-1:0] fetch_cnt,
  output logic [FETCH_CNT_W-1:0] bubble_cnt
`endif
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic [WIDTH_JDATA-1:0] pc_reg;
  logic                   inflight_reg;
  logic                   kill_reg;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            occupancy;
  logic                   issue;
  logic                   push;
  logic                   pop;

  // Credit counts buffered plus in-flight words; a same-cycle pop is not credited.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
  assign issue     = !rst && !jump && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign push      = inflight_reg && !kill_reg && !jump;
  assign pop       = next_instr && valid && !jump;
  assign valid     = (fifo_count != '0);
  assign imem_rd   = issue;
  assign imem_addr = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= '0;
      inflight_reg <= 1'b0;
      kill_reg     <= 1'b0;
    end else begin
      inflight_reg <= issue;
      kill_reg     <= jump && !issue;
      if (jump) begin
        pc_reg <= jdata;
      end else if (issue) begin
        pc_reg <= pc_reg + WIDTH_JDATA'(1);
      end
    end
  end

  instr_fifo #(
    .WIDTH (WIDTH_INSTR),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (jump),
    .din   (imem_rdata),
    .head  (instr),
    .count (fifo_count)
  );

`ifdef FETCH_PERF_EN
  logic [FETCH_CNT_W-1:0] fetch_cnt_reg;
  logic [FETCH_CNT_W-1:0] bubble_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (push && (fetch_cnt_reg != '1)) begin
        fetch_cnt_reg <= fetch_cnt_reg + FETCH_CNT_W'(1);
      end
      if (!valid && (bubble_cnt_reg != '1)) begin
        bubble_cnt_reg <= bubble_cnt_reg + FETCH_CNT_W'(1);
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: streaming table, stall, jump flush, PC wrap, mid-stream reset.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_instr;
  logic        jump;
  pc_t         jdata;
  logic        imem_rd;
  pc_t         imem_addr;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [15:0] instr;
  logic        valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] s_fetch;
  logic [31:0] s_bubble;
`endif

  int checks   = 0;
  int failures = 0;
  int sb_pops  = 0;
  logic [15:0] exp_q[$];

  logic        s_rd;
  pc_t         s_addr;
  logic        s_valid;
  logic [15:0] s_instr;

  typedef struct {
    logic        ni;
    logic        jp;
    pc_t         jd;
    logic        exp_rd;
    pc_t         exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
  } vec_t;
  vec_t vecs[10];

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .next_instr (next_instr),
    .jump       (jump),
    .jdata      (jdata),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .valid      (valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input pc_t a);
    return 16'h1000 + a[15:0];
  endfunction

  // Synchronous memory: data one cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem_word(imem_addr);
    else         imem_rdata <= 16'hDEAD;
  end

  // Credit rule must never let a push land in a full FIFO.
  always @(negedge clk) begin
    if (!rst && dut.push && !dut.pop && (dut.fifo_count == 3'(DEF_FIFO_DEPTH))) begin
      failures++;
      $display("FAIL push_into_full actual=push_when_full required=no_push t=%0t", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, score any pop, advance.
  task automatic cyc(input logic ni, input logic jp, input pc_t jd);
    logic [15:0] e;
    next_instr = ni;
    jump       = jp;
    jdata      = jd;
    @(negedge clk);
    s_rd    = imem_rd;
    s_addr  = imem_addr;
    s_valid = valid;
    s_instr = instr;
`ifdef FETCH_PERF_EN
    s_fetch  = fetch_cnt;
    s_bubble = bubble_cnt;
`endif
    if (!rst && ni && !jp && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty actual=%h required=none", instr);
      end else begin
        e = exp_q.pop_front();
        sb_pops++;
        $display("pop instr=%h expected=%h", instr, e);
        if (instr !== e) begin
          failures++;
          $display("FAIL scoreboard_instr actual=%h required=%h", instr, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic fill_q(input logic [15:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(base + 16'(k));
    sb_pops = 0;
  endtask

  initial begin
    int rd_cnt;
    int bubbles;
    logic got;

    for (int k = 0; k < 10; k++) begin
      vecs[k].ni        = 1'b1;
      vecs[k].jp        = 1'b0;
      vecs[k].jd        = '0;
      vecs[k].exp_rd    = 1'b1;
      vecs[k].exp_addr  = pc_t'(k);
      vecs[k].exp_valid = (k >= 2);
      vecs[k].exp_instr = (k >= 2) ? 16'h1000 + 16'(k - 2) : 16'h0000;
    end

    rst = 1'b1; next_instr = 1'b0; jump = 1'b0; jdata = '0;
    @(posedge clk); #1;

    // Reset state
    do_reset(3);
    chk("reset_valid", 32'(s_valid), 32'd0);
    chk("reset_rd", 32'(s_rd), 32'd0);
    chk("reset_instr", 32'(s_instr), 32'h0);
`ifdef FETCH_PERF_EN
    chk("reset_fetch_cnt", s_fetch, 32'd0);
    chk("reset_bubble_cnt", s_bubble, 32'd0);
`endif

    // Streaming from reset, consumer always ready
    fill_q(16'h1000, 20);
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].ni, vecs[i].jp, vecs[i].jd);
      chk("tbl_rd", 32'(s_rd), 32'(vecs[i].exp_rd));
      chk("tbl_addr", 32'(s_addr), 32'(vecs[i].exp_addr));
      chk("tbl_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk("tbl_instr", 32'(s_instr), 32'(vecs[i].exp_instr));
    end
    chk("tbl_pops", sb_pops, 8);
`ifdef FETCH_PERF_EN
    chk("tbl_fetch_cnt", s_fetch, 32'd8);
    chk("tbl_bubble_cnt", s_bubble, 32'd2);
`endif

    // Stall from reset: credit limits reads to four
    do_reset(2);
    fill_q(16'h1000, 30);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, '0);
      if (s_rd) begin
        chk("stall_addr", 32'(s_addr), 32'(rd_cnt));
        rd_cnt++;
      end
    end
    chk("stall_reads", rd_cnt, 4);
    chk("stall_rd_low", 32'(s_rd), 32'd0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_instr", 32'(s_instr), 32'h1000);
    got = 1'b0;
    bubbles = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (s_rd && !got) begin
        got = 1'b1;
        chk("resume_addr", 32'(s_addr), 32'd4);
      end
      if (!s_valid) bubbles++;
    end
    chk("resume_seen", 32'(got), 32'd1);
    chk("resume_bubbles", bubbles, 0);
    chk("resume_pops", sb_pops, 12);

    // Jump with three buffered, one in flight, and a same-cycle next_instr
    do_reset(2);
    fill_q(16'h1000, 10);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 24'h000040);
    chk("jmp_pre_valid", 32'(s_valid), 32'd1);
    chk("jmp_rd", 32'(s_rd), 32'd0);
    fill_q(16'h1040, 10);
    cyc(1'b1, 1'b0, '0);
    chk("jmp1_rd", 32'(s_rd), 32'd1);
    chk("jmp1_addr", 32'(s_addr), 32'h40);
    chk("jmp1_valid", 32'(s_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("jmp2_valid", 32'(s_valid), 32'd0);
    chk("jmp2_addr", 32'(s_addr), 32'h41);
    cyc(1'b1, 1'b0, '0);
    chk("jmp3_valid", 32'(s_valid), 32'd1);
    chk("jmp3_instr", 32'(s_instr), 32'h1040);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0);
    chk("jmp_pops", sb_pops, 5);

    // PC wrap at the top of the address space
    cyc(1'b1, 1'b1, 24'hFFFFFF);
    fill_q(16'h0FFF, 6);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_rd", 32'(s_rd), 32'd1);
    chk("wrap_addr_top", 32'(s_addr), 32'hFFFFFF);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_addr_zero", 32'(s_addr), 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
    chk("wrap_pops", sb_pops, 3);

    // Reset with a full FIFO
    do_reset(2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0);
    chk("full_valid", 32'(s_valid), 32'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("midrst_valid", 32'(s_valid), 32'd0);
    chk("midrst_rd", 32'(s_rd), 32'd0);
`ifdef FETCH_PERF_EN
    chk("midrst_fetch_cnt", s_fetch, 32'd0);
    chk("midrst_bubble_cnt", s_bubble, 32'd0);
`endif
    rst = 1'b0;
    fill_q(16'h1000, 10);
    cyc(1'b1, 1'b0, '0);
    chk("refetch_rd", 32'(s_rd), 32'd1);
    chk("refetch_addr", 32'(s_addr), 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0);
    chk("refetch_pops", sb_pops, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
